// File: rtl/lcd_nibble_driver.sv
// HD44780 4-bit write driver: sends one latched byte as two nibbles with E strobes,
// waits out the instruction execution time, then pulses driver_rdy.
module lcd_nibble_driver #(
  parameter int T_AS        = 2,
  parameter int T_PW        = 13,
  parameter int T_H         = 1,
  parameter int T_NIB       = 50,
  parameter int T_EXEC      = 2100,
  parameter int T_EXEC_LONG = 82000,
  parameter int T_GAP       = 2,
  parameter int CNT_W       = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] data_in,
  input  logic       rs_in,
  output logic       driver_rdy,
  output logic       busy,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [3:0] lcd_db
);

  // state     | meaning
  // IDLE      | waiting for enable; latches byte and RS
  // SETUP_HI  | high nibble on DB, address setup before E rise
  // PULSE_HI  | E high for the high nibble
  // HOLD_HI   | DB/RS held after E fall
  // NIB_GAP   | pause between the two nibble transfers
  // SETUP_LO  | low nibble on DB, setup before E rise
  // PULSE_LO  | E high for the low nibble
  // HOLD_LO   | DB/RS held after E fall
  // EXEC_WAIT | panel executing the instruction
  // DONE      | driver_rdy pulse
  // RECOVER   | lets the controller update its command; enable ignored
  typedef enum logic [3:0] {
    IDLE, SETUP_HI, PULSE_HI, HOLD_HI, NIB_GAP,
    SETUP_LO, PULSE_LO, HOLD_LO, EXEC_WAIT, DONE, RECOVER
  } state_t;

  localparam logic [CNT_W-1:0] L_AS   = CNT_W'(T_AS - 1);
  localparam logic [CNT_W-1:0] L_PW   = CNT_W'(T_PW - 1);
  localparam logic [CNT_W-1:0] L_H    = CNT_W'(T_H - 1);
  localparam logic [CNT_W-1:0] L_NIB  = CNT_W'(T_NIB - 1);
  localparam logic [CNT_W-1:0] L_EXEC = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] L_LONG = CNT_W'(T_EXEC_LONG - 1);
  localparam logic [CNT_W-1:0] L_GAP  = CNT_W'(T_GAP - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer, timer_nxt, last;
  logic [7:0]       data_q, data_nxt;
  logic             rs_q, rs_nxt;
  logic             long_cmd;
  logic             e_nxt, rdy_nxt, busy_nxt, lcd_rs_nxt;
  logic [3:0]       db_nxt;

  assign lcd_rw   = 1'b0;
  // CLEAR and HOME need the long execution wait
  assign long_cmd = !rs_q && (data_q == 8'h01 || data_q == 8'h02);

  always_comb begin
    last = '0;
    case (state)
      SETUP_HI, SETUP_LO: last = L_AS;
      PULSE_HI, PULSE_LO: last = L_PW;
      HOLD_HI, HOLD_LO:   last = L_H;
      NIB_GAP:            last = L_NIB;
      EXEC_WAIT:          last = long_cmd ? L_LONG : L_EXEC;
      RECOVER:            last = L_GAP;
      default:            last = '0;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer + 1'b1;
    data_nxt   = data_q;
    rs_nxt     = rs_q;
    e_nxt      = lcd_e;
    rdy_nxt    = 1'b0;
    busy_nxt   = busy;
    lcd_rs_nxt = lcd_rs;
    db_nxt     = lcd_db;
    if (state == IDLE) begin
      timer_nxt = '0;
      if (enable) begin
        state_nxt  = SETUP_HI;
        data_nxt   = data_in;
        rs_nxt     = rs_in;
        busy_nxt   = 1'b1;
        lcd_rs_nxt = rs_in;
        db_nxt     = data_in[7:4];
      end
    end else if (timer == last) begin
      timer_nxt = '0;
      case (state)
        SETUP_HI:  begin state_nxt = PULSE_HI; e_nxt = 1'b1; end
        PULSE_HI:  begin state_nxt = HOLD_HI;  e_nxt = 1'b0; end
        HOLD_HI:   state_nxt = NIB_GAP;
        NIB_GAP:   begin state_nxt = SETUP_LO; db_nxt = data_q[3:0]; end
        SETUP_LO:  begin state_nxt = PULSE_LO; e_nxt = 1'b1; end
        PULSE_LO:  begin state_nxt = HOLD_LO;  e_nxt = 1'b0; end
        HOLD_LO:   state_nxt = EXEC_WAIT;
        EXEC_WAIT: begin state_nxt = DONE; rdy_nxt = 1'b1; end
        DONE:      state_nxt = RECOVER;
        RECOVER:   begin state_nxt = IDLE; busy_nxt = 1'b0; end
        default:   state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      data_q     <= '0;
      rs_q       <= 1'b0;
      lcd_e      <= 1'b0;
      driver_rdy <= 1'b0;
      busy       <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_db     <= '0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      data_q     <= data_nxt;
      rs_q       <= rs_nxt;
      lcd_e      <= e_nxt;
      driver_rdy <= rdy_nxt;
      busy       <= busy_nxt;
      lcd_rs     <= lcd_rs_nxt;
      lcd_db     <= db_nxt;
    end
  end

endmodule

// File: tb/tb_lcd_nibble_driver.sv
// Scoreboard bench for lcd_nibble_driver: expected E edges and rdy pulses are queued
// from the timing rules; a negedge monitor pops and compares each observed event.
module tb_lcd_nibble_driver;
  localparam int T_AS = 2, T_PW = 13, T_H = 1, T_NIB = 50;
  localparam int T_EXEC = 2100, T_EXEC_LONG = 82000, T_GAP = 2;
  localparam int K_RISE = 0, K_FALL = 1, K_RDY = 2;

  logic       clk = 1'b0, rst_n = 1'b0, enable = 1'b0, rs_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       driver_rdy, busy, lcd_rs, lcd_rw, lcd_e;
  logic [3:0] lcd_db;

  int cyc = 0;
  int checks = 0, errors = 0;

  typedef struct {int kind; int at; int db; int rs;} ev_t;
  ev_t exp_q[$];

  lcd_nibble_driver dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .data_in(data_in), .rs_in(rs_in),
    .driver_rdy(driver_rdy), .busy(busy), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_e(lcd_e), .lcd_db(lcd_db)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Expected observable events of one transfer latched at edge l
  task automatic push_xfer(input int l, input logic [7:0] d, input logic r, output int rdy_at);
    int e1, f1, e2, f2, ex;
    ex = (!r && (d == 8'h01 || d == 8'h02)) ? T_EXEC_LONG : T_EXEC;
    e1 = l + T_AS;
    f1 = e1 + T_PW;
    e2 = f1 + T_H + T_NIB + T_AS;
    f2 = e2 + T_PW;
    rdy_at = f2 + T_H + ex;
    exp_q.push_back('{K_RISE, e1, int'(d[7:4]), int'(r)});
    exp_q.push_back('{K_FALL, f1, int'(d[7:4]), int'(r)});
    exp_q.push_back('{K_RISE, e2, int'(d[3:0]), int'(r)});
    exp_q.push_back('{K_FALL, f2, int'(d[3:0]), int'(r)});
    exp_q.push_back('{K_RDY, rdy_at, int'(d[3:0]), int'(r)});
  endtask

  task automatic observe(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event kind %0d at cycle %0d: got an event expected none", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc, e.at);
      chk("event_db", int'(lcd_db), e.db);
      chk("event_rs", int'(lcd_rs), e.rs);
      chk("event_rw", int'(lcd_rw), 0);
    end
  endtask

  logic pe = 1'b0, pr = 1'b0;
  always @(negedge clk) begin
    if (lcd_e !== pe) observe(lcd_e ? K_RISE : K_FALL);
    if (driver_rdy && !pr) observe(K_RDY);
    if (driver_rdy && pr) chk("rdy_width", int'(pr), 0);
    pe = lcd_e;
    pr = driver_rdy;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    int n = 0;
    while (cyc < target && n < 100000) begin step(); n++; end
  endtask

  task automatic drain(input int budget, input bit scramble);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
      if (scramble) begin
        data_in = 8'($urandom);
        rs_in   = 1'($urandom);
      end
    end
    chk("drain_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  function automatic logic [7:0] rand_byte(input logic r);
    logic [7:0] d;
    d = 8'($urandom);
    if (!r && (d == 8'h01 || d == 8'h02)) d = 8'h38;
    return d;
  endfunction

  initial begin
    int l, l2, rdy1, rdy2;
    logic [7:0] d2;
    logic r2;

    // reset held with enable asserted
    enable  = 1'b1;
    data_in = 8'($urandom);
    rs_in   = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("reset_outputs", int'({lcd_e, driver_rdy, busy, lcd_rs, lcd_rw, lcd_db}), 0);
    end
    step();
    enable = 1'b0;
    rst_n  = 1'b1;
    repeat (3) step();
    chk("idle_busy", int'(busy), 0);

    // single byte 'A' as data
    data_in = 8'h41; rs_in = 1'b1; enable = 1'b1;
    l = cyc + 1;
    push_xfer(l, 8'h41, 1'b1, rdy1);
    step();
    enable = 1'b0;
    chk("busy_after_latch", int'(busy), 1);
    drain(2400, 1'b1);
    chk("busy_in_recover", int'(busy), 1);
    step(); step();
    chk("busy_after_recover", int'(busy), 0);
    repeat (3) step();

    // CLEAR as instruction: long execution wait
    data_in = 8'h01; rs_in = 1'b0; enable = 1'b1;
    l = cyc + 1;
    push_xfer(l, 8'h01, 1'b0, rdy1);
    step();
    enable = 1'b0;
    drain(83000, 1'b1);
    repeat (5) step();

    // back-to-back: 0x01 as data (normal wait), then a random byte while enable stays high
    r2 = 1'($urandom);
    d2 = rand_byte(r2);
    data_in = 8'h01; rs_in = 1'b1; enable = 1'b1;
    l = cyc + 1;
    push_xfer(l, 8'h01, 1'b1, rdy1);
    l2 = rdy1 + T_GAP + 2;
    push_xfer(l2, d2, r2, rdy2);
    wait_cyc(rdy1 + 2);
    data_in = d2; rs_in = r2;
    wait_cyc(l2);
    enable = 1'b0;
    drain(5000, 1'b0);
    repeat (5) step();

    // abort by reset during the first E-high window
    data_in = rand_byte(1'b1); rs_in = 1'b1; enable = 1'b1;
    l = cyc + 1;
    exp_q.push_back('{K_RISE, l + T_AS, int'(data_in[7:4]), 1});
    exp_q.push_back('{K_FALL, l + 8, 0, 0});
    step();
    enable = 1'b0;
    wait_cyc(l + 8);
    rst_n = 1'b0;
    #1;
    chk("abort_e_low", int'(lcd_e), 0);
    chk("abort_busy_low", int'(busy), 0);
    repeat (3) step();
    rst_n = 1'b1;
    chk("abort_drained", exp_q.size(), 0);
    step();

    // fresh request after abort, enable dropped at edge 3
    r2 = 1'($urandom);
    d2 = rand_byte(r2);
    data_in = d2; rs_in = r2; enable = 1'b1;
    l = cyc + 1;
    push_xfer(l, d2, r2, rdy1);
    wait_cyc(l + 3);
    enable = 1'b0;
    drain(2400, 1'b1);
    repeat (4) step();
    chk("final_idle", int'({busy, lcd_e, driver_rdy}), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
